// File: rtl/ppm_pkg.sv
// Shared encodings for the PPM frame sequencer: symbol kinds, FSM states, error codes.
package ppm_pkg;

    typedef enum logic [1:0] {
        SYM_DATA = 2'b00,
        SYM_SOF  = 2'b01,
        SYM_EOF  = 2'b10,
        SYM_VIOL = 2'b11
    } sym_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_OVF   = 3'd1;
    localparam logic [2:0] ERR_PART  = 3'd2;
    localparam logic [2:0] ERR_EMPTY = 3'd3;
    localparam logic [2:0] ERR_VIOL  = 3'd4;
    localparam logic [2:0] ERR_ABORT = 3'd5;
    localparam logic [2:0] ERR_TO    = 3'd6;
    localparam logic [2:0] ERR_LEN   = 3'd7;

endpackage

// File: rtl/ppm_frame_ctrl_if.sv
// Symbol input strobe and valid/ready byte output between slicer, sequencer and byte buffer.
interface ppm_frame_ctrl_if;
    logic       sym_valid;
    logic [1:0] sym_kind;
    logic [1:0] sym_data;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output sym_valid, sym_kind, sym_data, byte_ready,
        input  byte_data, byte_valid
    );

    modport slave (
        input  sym_valid, sym_kind, sym_data, byte_ready,
        output byte_data, byte_valid
    );
endinterface

// File: rtl/ppm_byte_asm.sv
// Packs 2-bit data symbols MSB first; byte_done flags the fourth symbol, asm_byte is the full byte then.
module ppm_byte_asm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       shift_en,
    input  logic [1:0] sym_in,
    output logic       byte_done,
    output logic [7:0] asm_byte,
    output logic [1:0] sym_cnt
);
    logic [5:0] shift_reg;
    logic [1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (clr) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[3:0], sym_in};
            cnt_reg   <= cnt_reg + 2'd1;
        end
    end

    // The fourth symbol is combined directly so the byte can load in the same cycle.
    assign byte_done = shift_en && (cnt_reg == 2'd3);
    assign asm_byte  = {shift_reg, sym_in};
    assign sym_cnt   = cnt_reg;
endmodule

// File: rtl/ppm_frame_ctrl.sv
// PPM frame sequencer: SOF/EOF framing, byte handshake, error reporting.
// Optional PPM_FRAME_STATS_EN adds saturating frame_ok_cnt/frame_err_cnt with stats_clr.
module ppm_frame_ctrl
    import ppm_pkg::*;
#(
    parameter int MAX_BYTES   = 64,
    parameter int CNT_W       = 7,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    ppm_frame_ctrl_if.slave   bus,
    output logic              frame_done,
    output logic              frame_err,
    output logic [2:0]        err_code,
    output logic [CNT_W-1:0]  byte_count,
    output logic              busy
`ifdef PPM_FRAME_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       frame_ok_cnt,
    output logic [15:0]       frame_err_cnt
`endif
);
    state_t             state_reg, state_next;
    logic [7:0]         byte_data_reg, byte_data_next;
    logic               byte_valid_reg, byte_valid_next;
    logic               frame_done_reg, frame_done_next;
    logic               frame_err_reg, frame_err_next;
    logic [2:0]         err_code_reg, err_code_next;
    logic [CNT_W-1:0]   byte_count_reg, byte_count_next;
    logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
    logic               sof_pend_reg, sof_pend_next;

    logic               asm_clr, asm_shift, byte_done;
    logic [7:0]         asm_byte;
    logic [1:0]         sym_cnt;
    logic               err_hit;
    logic [2:0]         err_sel;
    logic               is_data, is_sof, is_eof, is_viol, xfer;

    assign is_data = bus.sym_valid && (bus.sym_kind == SYM_DATA);
    assign is_sof  = bus.sym_valid && (bus.sym_kind == SYM_SOF);
    assign is_eof  = bus.sym_valid && (bus.sym_kind == SYM_EOF);
    assign is_viol = bus.sym_valid && (bus.sym_kind == SYM_VIOL);
    assign xfer    = byte_valid_reg && bus.byte_ready;

    ppm_byte_asm u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (asm_clr),
        .shift_en  (asm_shift),
        .sym_in    (bus.sym_data),
        .byte_done (byte_done),
        .asm_byte  (asm_byte),
        .sym_cnt   (sym_cnt)
    );

    always_comb begin
        state_next      = state_reg;
        byte_data_next  = byte_data_reg;
        byte_valid_next = xfer ? 1'b0 : byte_valid_reg;
        frame_done_next = 1'b0;
        frame_err_next  = 1'b0;
        err_code_next   = err_code_reg;
        byte_count_next = byte_count_reg;
        to_cnt_next     = to_cnt_reg;
        sof_pend_next   = sof_pend_reg;
        asm_clr         = 1'b0;
        asm_shift       = 1'b0;
        err_hit         = 1'b0;
        err_sel         = ERR_NONE;

        case (state_reg)
            ST_IDLE: begin
                if (is_sof) begin
                    state_next      = ST_RECV;
                    byte_count_next = '0;
                    err_code_next   = ERR_NONE;
                    to_cnt_next     = '0;
                    asm_clr         = 1'b1;
                end
            end
            ST_RECV: begin
                if (bus.sym_valid) begin
                    to_cnt_next = '0;
                end else if (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1)) begin
                    err_hit = 1'b1;
                    err_sel = ERR_TO;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end

                if (is_data) begin
                    asm_shift = 1'b1;
                    if (byte_done) begin
                        if (byte_valid_reg && !bus.byte_ready) begin
                            err_hit = 1'b1;
                            err_sel = ERR_OVF;
                        end else if (byte_count_reg == CNT_W'(MAX_BYTES)) begin
                            err_hit = 1'b1;
                            err_sel = ERR_LEN;
                        end else begin
                            byte_data_next  = asm_byte;
                            byte_valid_next = 1'b1;
                            byte_count_next = byte_count_reg + CNT_W'(1);
                        end
                    end
                end else if (is_eof) begin
                    if (sym_cnt != 2'd0) begin
                        err_hit = 1'b1;
                        err_sel = ERR_PART;
                    end else if (byte_count_reg == '0) begin
                        err_hit = 1'b1;
                        err_sel = ERR_EMPTY;
                    end else begin
                        state_next    = ST_FLUSH;
                        sof_pend_next = 1'b0;
                    end
                end else if (is_viol) begin
                    err_hit = 1'b1;
                    err_sel = ERR_VIOL;
                end else if (is_sof) begin
                    // Abort and restart in place; a pending output byte keeps its handshake.
                    frame_err_next  = 1'b1;
                    err_code_next   = ERR_ABORT;
                    byte_count_next = '0;
                    to_cnt_next     = '0;
                    asm_clr         = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (is_sof) begin
                    sof_pend_next = 1'b1;
                end
                if (!byte_valid_reg) begin
                    frame_done_next = 1'b1;
                    sof_pend_next   = 1'b0;
                    if (sof_pend_reg || is_sof) begin
                        state_next      = ST_RECV;
                        byte_count_next = '0;
                        err_code_next   = ERR_NONE;
                        to_cnt_next     = '0;
                        asm_clr         = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (err_hit) begin
            frame_err_next = 1'b1;
            err_code_next  = err_sel;
            state_next     = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            byte_data_reg  <= '0;
            byte_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            err_code_reg   <= ERR_NONE;
            byte_count_reg <= '0;
            to_cnt_reg     <= '0;
            sof_pend_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_data_reg  <= byte_data_next;
            byte_valid_reg <= byte_valid_next;
            frame_done_reg <= frame_done_next;
            frame_err_reg  <= frame_err_next;
            err_code_reg   <= err_code_next;
            byte_count_reg <= byte_count_next;
            to_cnt_reg     <= to_cnt_next;
            sof_pend_reg   <= sof_pend_next;
        end
    end

    assign bus.byte_data  = byte_data_reg;
    assign bus.byte_valid = byte_valid_reg;
    assign frame_done     = frame_done_reg;
    assign frame_err      = frame_err_reg;
    assign err_code       = err_code_reg;
    assign byte_count     = byte_count_reg;
    assign busy           = (state_reg == ST_RECV);

`ifdef PPM_FRAME_STATS_EN
    logic [15:0] ok_cnt_reg, err_cnt_reg;

    // Counts follow the visible pulses, so each increments the cycle after its pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_cnt_reg  <= '0;
            err_cnt_reg <= '0;
        end else if (stats_clr) begin
            ok_cnt_reg  <= '0;
            err_cnt_reg <= '0;
        end else begin
            if (frame_done_reg && (ok_cnt_reg != 16'hFFFF)) begin
                ok_cnt_reg <= ok_cnt_reg + 16'd1;
            end
            if (frame_err_reg && (err_cnt_reg != 16'hFFFF)) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
        end
    end

    assign frame_ok_cnt  = ok_cnt_reg;
    assign frame_err_cnt = err_cnt_reg;
`endif
endmodule

// File: doc/ppm_frame_ctrl.md
Name: ppm_frame_ctrl

Overview:
Frame-level sequencer for the PPM decoder datapath. It consumes classified PPM symbols (data/SOF/EOF/violation) from the symbol slicer and tracks frame state. It assembles 2-bit data symbols into bytes, MSB first, and presents them on a valid/ready byte interface to the downstream byte buffer. It also reports frame completion, errors and byte count, so the decoder output is only qualified between a valid SOF and EOF.

Parameters:
MAX_BYTES, 64, maximum payload bytes per frame; the frame errors if exceeded
CNT_W, 7, width of byte_count; must satisfy 2**CNT_W > MAX_BYTES
TIMEOUT_CYC, 1024, clk cycles allowed between sym_valid pulses while in RECV before the frame aborts
TO_W, 10, timeout counter width; must satisfy 2**TO_W >= TIMEOUT_CYC

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
sym_valid  input  1  one-cycle strobe; sym_kind/sym_data valid
sym_kind  input  2  00 DATA, 01 SOF, 10 EOF, 11 VIOL (slot violation)
sym_data  input  2  data symbol value; used only when sym_kind=DATA
byte_data  output  8  assembled byte
byte_valid  output  1  byte_data valid; held until accepted
byte_ready  input  1  downstream accepts byte when byte_valid&&byte_ready
frame_done  output  1  one-cycle pulse: frame ended cleanly
frame_err  output  1  one-cycle pulse: frame aborted
err_code  output  3  reason for last frame_err; held until the next frame_err or SOF
byte_count  output  CNT_W  bytes assembled in current/last frame
busy  output  1  high in RECV

Behaviour:
- Reset is decided: rst_n, asynchronous, active-low; clock clk. All state is reset asynchronously.
- Reset values: state IDLE, byte_data 0, byte_valid 0, frame_done 0, frame_err 0, err_code 0, byte_count 0, busy 0, symbol counter 0, timeout counter 0.
- FSM has three states: IDLE, RECV, FLUSH.
- IDLE: DATA, EOF and VIOL symbols are ignored. SOF -> RECV; clears byte_count, symbol count, err_code and the timeout counter.
- RECV, DATA: shifts sym_data into the assembly register (first symbol -> bits[7:6], fourth -> bits[1:0]). On the fourth symbol:
  - if byte_valid=1 and byte_ready=0 in that same cycle -> overflow error;
  - else the byte is loaded into byte_data, byte_valid=1 next cycle, and byte_count increments.
- RECV, byte limit: a byte completing when byte_count==MAX_BYTES -> error, with no load.
- RECV, EOF:
  - symbol count mod 4 != 0 -> error (partial byte);
  - byte_count==0 -> error (empty frame);
  - otherwise -> FLUSH.
- RECV, VIOL -> error.
- RECV, SOF: frame_err pulse (aborted), then immediately restart in RECV with counters cleared. A pending output byte is not dropped.
- RECV, timeout: the counter increments on each cycle without sym_valid and clears on sym_valid. Reaching TIMEOUT_CYC-1 -> error.
- FLUSH: waits for byte_valid=0 (last byte accepted), then pulses frame_done for one cycle and returns to IDLE. A SOF arriving in FLUSH is recorded and taken as soon as FLUSH exits: the FSM enters RECV instead of IDLE, in the same cycle as frame_done.
- Any error: frame_err pulses for one cycle the cycle after detection, err_code is set, and the FSM -> IDLE. byte_valid/byte_data, if pending, remain and complete their handshake. byte_count holds its final value.
- err_code values: 1 overflow, 2 partial, 3 empty, 4 VIOL, 5 aborted by SOF, 6 timeout, 7 length.
- Handshake: byte_valid falls the cycle after a byte_valid&&byte_ready transfer, unless a new byte loads that same cycle, in which case it stays 1 with new data. byte_data is stable while byte_valid&&!byte_ready.
- Latency: 4th DATA strobe at cycle N -> byte_valid=1 at N+1.
- frame_done and frame_err are never high together.
- busy = (state==RECV).

Optional Feature:
PPM_FRAME_STATS_EN
- When defined: adds output ports frame_ok_cnt[15:0] and frame_err_cnt[15:0]. Each is a saturating count of frame_done and frame_err pulses respectively; both reset to 0. It also adds input stats_clr, a synchronous clear of both counters that takes priority over an increment in the same cycle.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package ppm_pkg holds:
  - sym_kind encodings (SYM_DATA, SYM_SOF, SYM_EOF, SYM_VIOL);
  - the FSM state enum (ST_IDLE, ST_RECV, ST_FLUSH);
  - err_code constants (ERR_OVF … ERR_LEN).
- One sub-module, ppm_byte_asm: the 2-bit shift register plus 2-bit symbol counter. It outputs byte_done and asm_byte and has a synchronous clear. The FSM, timeout, handshake register and counters stay in ppm_frame_ctrl.

Test Plan:
- SOF, DATA 3,0,2,1, EOF, byte_ready=1 -> byte_data=0xC9 with byte_valid for 1 cycle, then frame_done pulse; byte_count=1, err_code=0.
- SOF, 8 DATA symbols with byte_ready=0 held until after the 2nd byte completes -> frame_err, err_code=1 (overflow); the first byte is still held and is delivered once byte_ready=1.
- SOF, DATA×6, EOF -> frame_err with err_code=2; SOF then immediate EOF -> err_code=3.
- SOF, DATA×2, then no sym_valid for TIMEOUT_CYC cycles -> frame_err, err_code=6, busy=0; a subsequent valid frame completes normally.
- SOF, DATA×4, SOF, DATA×4, EOF -> frame_err with err_code=5 after the second SOF, then frame_done with byte_count=1; two bytes are delivered in total.
- Assert rst_n=0 mid-frame with byte_valid=1 -> all outputs 0 immediately; after release, DATA/EOF are ignored until SOF.
